// File: rtl/bullet_ctrl.sv
// Fire scheduler for a pool of bullet slots: button edge detect, lowest-free-slot
// allocation, shot cooldown, move tick and collision scan index. Define AUTOFIRE_EN for hold-to-fire.
module bullet_ctrl #(
    parameter int NUM_SLOTS      = 4,
    parameter int TICK_DIV       = 600000,
    parameter int COOLDOWN_TICKS = 3,
    parameter int CNT_W          = 8
) (
    input  logic                         clk_12MHz,
    input  logic                         reset,
    input  logic                         game_run,
    input  logic                         shoot_btn,
    input  logic [NUM_SLOTS-1:0]         slot_flying,
    output logic [NUM_SLOTS-1:0]         fire,
    output logic                         move_tick,
    output logic [$clog2(NUM_SLOTS)-1:0] scan_idx,
    output logic                         busy,
    output logic [CNT_W-1:0]             shots_fired
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CD_W  = $clog2(COOLDOWN_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FIRE,
        COOLDOWN
    } state_t;

    state_t               state, state_nxt;
    logic [CD_W-1:0]      cool_cnt, cool_nxt;
    logic [NUM_SLOTS-1:0] fire_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 btn_sync1, btn_sync2;
    logic                 any_free;
    logic [IDX_W-1:0]     free_idx;
    logic                 req;

`ifdef AUTOFIRE_EN
    // A held button keeps requesting; cooldown alone paces the shots.
    assign req = btn_sync2;
`else
    logic btn_prev;
    assign req = btn_sync2 & ~btn_prev;
`endif

    assign move_tick = game_run && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign busy      = (state != IDLE) || (&slot_flying);

    // Lowest-index free slot, evaluated on the current slot_flying.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_flying[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain the synchronizer stages.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            btn_sync1   <= 1'b0;
            btn_sync2   <= 1'b0;
`ifndef AUTOFIRE_EN
            btn_prev    <= 1'b0;
`endif
            div_cnt     <= '0;
            scan_idx    <= '0;
            shots_fired <= '0;
        end else begin
            btn_sync1 <= shoot_btn;
            btn_sync2 <= btn_sync1;
`ifndef AUTOFIRE_EN
            btn_prev  <= btn_sync2;
`endif
            if (!game_run || move_tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);

            if (scan_idx == IDX_W'(NUM_SLOTS - 1))
                scan_idx <= '0;
            else
                scan_idx <= scan_idx + IDX_W'(1);

            if (state == FIRE && shots_fired != '1)
                shots_fired <= shots_fired + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state    <= IDLE;
            cool_cnt <= '0;
            fire     <= '0;
        end else begin
            state    <= state_nxt;
            cool_cnt <= cool_nxt;
            fire     <= fire_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cool_nxt  = cool_cnt;
        fire_nxt  = '0;
        if (!game_run) begin
            state_nxt = IDLE;
            cool_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (any_free) begin
                            state_nxt = FIRE;
                            fire_nxt  = NUM_SLOTS'(1) << free_idx;
                        end else begin
                            state_nxt = ARM;
                        end
                    end
                end
                ARM: begin
                    if (any_free) begin
                        state_nxt = FIRE;
                        fire_nxt  = NUM_SLOTS'(1) << free_idx;
                    end
                end
                FIRE: begin
                    state_nxt = COOLDOWN;
                    cool_nxt  = CD_W'(COOLDOWN_TICKS);
                end
                COOLDOWN: begin
                    if (move_tick) begin
                        if (cool_cnt <= CD_W'(1)) begin
                            state_nxt = IDLE;
                            cool_nxt  = '0;
                        end else begin
                            cool_nxt = cool_cnt - CD_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cool_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl: fire pulses are scoreboarded against a queue of
// expected one-hot targets; timing corners are checked inline.
module tb_bullet_ctrl;

    logic       clk_12MHz = 1'b0;
    logic       reset;
    logic       game_run;
    logic       shoot_btn;
    logic [3:0] slot_flying;
    logic [3:0] fire;
    logic       move_tick;
    logic [1:0] scan_idx;
    logic       busy;
    logic [7:0] shots_fired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_shots = 0;
    logic [3:0] exp_q[$];
    bit prev_fire_hi = 1'b0;

    typedef struct {
        logic [3:0] flying;
        logic [3:0] exp_fire;
    } vec_t;
    vec_t vecs[7];

    bullet_ctrl #(
        .NUM_SLOTS(4),
        .TICK_DIV(4),
        .COOLDOWN_TICKS(2),
        .CNT_W(8)
    ) dut (
        .clk_12MHz  (clk_12MHz),
        .reset      (reset),
        .game_run   (game_run),
        .shoot_btn  (shoot_btn),
        .slot_flying(slot_flying),
        .fire       (fire),
        .move_tick  (move_tick),
        .scan_idx   (scan_idx),
        .busy       (busy),
        .shots_fired(shots_fired)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_12MHz);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] f);
        exp_q.push_back(f);
        exp_shots++;
    endtask

    function automatic logic [31:0] sat_shots();
        return (exp_shots > 255) ? 32'd255 : 32'(exp_shots);
    endfunction

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic shot(input logic [3:0] flying, input logic [3:0] exp_fire);
        slot_flying = flying;
        shoot_btn   = 1'b1;
        push_exp(exp_fire);
        repeat (3) step();
        shoot_btn = 1'b0;
        wait_idle();
        repeat (2) step();
    endtask

    // Scoreboard: every fire pulse must match the oldest expected target.
    always @(negedge clk_12MHz) begin
        if (fire != 4'b0000) begin
            if (exp_q.size() == 0)
                check("unexpected_fire", 32'(fire), 32'd0);
            else
                check("fire_slot", 32'(fire), 32'(exp_q.pop_front()));
            check("no_back_to_back", 32'(prev_fire_hi), 32'd0);
        end
        prev_fire_hi = (fire != 4'b0000);
    end

    initial begin
        int ticks;
        int idle_seen;
        int pulses;
        logic [31:0] shots_snap;
        logic [1:0]  scan_exp;
        logic [3:0]  one_hot;

        vecs[0] = '{4'b0011, 4'b0100};
        vecs[1] = '{4'b0000, 4'b0001};
        vecs[2] = '{4'b0001, 4'b0010};
        vecs[3] = '{4'b0111, 4'b1000};
        vecs[4] = '{4'b1110, 4'b0001};
        vecs[5] = '{4'b1010, 4'b0001};
        vecs[6] = '{4'b1011, 4'b0100};

        reset       = 1'b1;
        game_run    = 1'b1;
        shoot_btn   = 1'b0;
        slot_flying = 4'b0000;

        // Reset state, then divider and scan index cadence.
        repeat (3) step();
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_move_tick", 32'(move_tick), 32'd0);
        check("rst_scan_idx", 32'(scan_idx), 32'd0);
        check("rst_shots", 32'(shots_fired), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("tick_cadence", 32'(move_tick), 32'((k % 4) == 3));
            check("scan_cadence", 32'(scan_idx), 32'(k % 4));
        end

        // Single shot: latency, count, and a press dropped during cooldown.
        ticks = 0;
        idle_seen = 0;
        shoot_btn = 1'b1;
        push_exp(4'b0001);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k < 3) check("latency_early", 32'(fire), 32'd0);
            if (k == 3) check("latency", 32'(fire), 32'b0001);
            if (k == 4) check("shots_one", 32'(shots_fired), 32'd1);
            if (k == 5) shoot_btn = 1'b0;
            if (k == 6) shoot_btn = 1'b1;
            if (k == 7) shoot_btn = 1'b0;
            if (k >= 4) begin
                if (!busy) begin
                    idle_seen = 1;
                    break;
                end
                if (move_tick) ticks++;
            end
        end
        check("cooldown_end", 32'(idle_seen), 32'd1);
        check("cooldown_ticks", 32'(ticks), 32'd2);
        repeat (6) step();
        check("dropped_press", 32'(shots_fired), 32'd1);

        // Allocation table: lowest free slot wins.
        foreach (vecs[i]) begin
            shot(vecs[i].flying, vecs[i].exp_fire);
            check("alloc_shots", 32'(shots_fired), sat_shots());
        end

        // All slots flying: wait in ARM, ignore extra presses, fire as soon as one frees.
        slot_flying = 4'b1111;
        shoot_btn   = 1'b1;
        repeat (3) step();
        shoot_btn = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_no_fire", 32'(fire), 32'd0);
        shoot_btn = 1'b1;
        repeat (3) step();
        shoot_btn = 1'b0;
        repeat (3) step();
        check("arm_still_waiting", 32'(fire), 32'd0);
        slot_flying = 4'b1101;
        push_exp(4'b0010);
        step();
        check("arm_release", 32'(fire), 32'b0010);
        wait_idle();
        repeat (4) step();
        check("arm_shots", 32'(shots_fired), sat_shots());

        // A slot freeing in the rise cycle is taken immediately.
        slot_flying = 4'b1111;
        shoot_btn   = 1'b1;
        push_exp(4'b1000);
        repeat (2) step();
        slot_flying = 4'b0111;
        step();
        shoot_btn = 1'b0;
        check("same_cycle_free", 32'(fire), 32'b1000);
        wait_idle();
        repeat (2) step();

        // game_run drop during cooldown.
        slot_flying = 4'b0000;
        shoot_btn   = 1'b1;
        push_exp(4'b0001);
        repeat (3) step();
        shoot_btn = 1'b0;
        repeat (2) step();
        check("gr_in_cooldown", 32'(busy), 32'd1);
        game_run   = 1'b0;
        shots_snap = sat_shots();
        step();
        check("gr_idle", 32'(busy), 32'd0);
        check("gr_shots_kept", 32'(shots_fired), shots_snap);
        scan_exp = scan_idx;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) shoot_btn = 1'b1;
            if (k == 4) shoot_btn = 1'b0;
            step();
            scan_exp = scan_exp + 2'd1;
            check("gr_no_tick", 32'(move_tick), 32'd0);
            check("gr_scan_runs", 32'(scan_idx), 32'(scan_exp));
        end
        check("gr_press_ignored", 32'(shots_fired), shots_snap);
        game_run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("gr_restart_tick", 32'(move_tick), 32'(k == 3));
            step();
        end

        // Held button: autofire rotates through slots, otherwise exactly one pulse.
        pulses = 0;
        slot_flying = 4'b0000;
        shoot_btn   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (fire != 4'b0000) begin
                one_hot = 4'b0001 << pulses;
                exp_q.push_back(one_hot);
                exp_shots++;
                pulses++;
                slot_flying = slot_flying | fire;
            end
        end
        shoot_btn = 1'b0;
`ifdef AUTOFIRE_EN
        check("autofire_pulses", 32'(pulses >= 3), 32'd1);
`else
        check("held_one_pulse", 32'(pulses), 32'd1);
`endif
        game_run = 1'b0;
        step();
        slot_flying = 4'b0000;
        step();
        game_run = 1'b1;
        repeat (4) step();
        check("held_shots", 32'(shots_fired), sat_shots());

        // Saturation of shots_fired.
        while (exp_shots < 257) begin
            shot(4'b0000, 4'b0001);
            if (exp_shots >= 254)
                check("saturate", 32'(shots_fired), sat_shots());
        end

        // Reset during FIRE clears the pulse and the count.
        shoot_btn = 1'b1;
        push_exp(4'b0001);
        repeat (3) step();
        check("pre_reset_fire", 32'(fire), 32'b0001);
        reset     = 1'b1;
        shoot_btn = 1'b0;
        step();
        exp_shots = 0;
        check("reset_fire_drop", 32'(fire), 32'd0);
        check("reset_shots_clr", 32'(shots_fired), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
- Scheduler for a pool of NUM_SLOTS bullet datapath slots. Each slot is one bullet instance with shoot/enable inputs and a bullet_flying output.
- Turns the player fire button into one-cycle, one-hot fire pulses aimed at the lowest free slot, and enforces a shot cooldown.
- Generates the common move tick that drives every slot's enable.
- Provides a round-robin scan index for the collision/render muxes.
- Sits between the input/debounce logic and the bullet slots.

Parameters:
- NUM_SLOTS, 4, number of bullet slots managed (2..8).
- TICK_DIV, 600000, clk_12MHz cycles per move_tick (20 Hz).
- COOLDOWN_TICKS, 3, move_ticks required between consecutive shots (>=1).
- CNT_W, 8, width of shots_fired.

Ports:
- clk_12MHz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- game_run  in  1  high while the game is active; low freezes the scheduler.
- shoot_btn  in  1  raw, asynchronous fire button level.
- slot_flying  in  NUM_SLOTS  bullet_flying from each slot.
- fire  out  NUM_SLOTS  one-hot, one-cycle shoot pulse to a slot.
- move_tick  out  1  one-cycle pulse every TICK_DIV cycles; drives slot enable.
- scan_idx  out  $clog2(NUM_SLOTS)  slot index currently presented to the collision mux.
- busy  out  1  high when not in IDLE or when all slots are flying.
- shots_fired  out  CNT_W  count of fire pulses issued.

Behaviour:
- Reset (synchronous, takes priority over everything): fire=0, move_tick=0, scan_idx=0, shots_fired=0, divider=0, cooldown counter=0, synchronizers=0, state=IDLE. busy is computed from state and slot_flying.
- Button path: 2-FF synchronizer, then a previous-value register. rise = sync2 & ~prev.
  - Fixed latency: fire goes high in the 3rd cycle after the first clock edge that samples shoot_btn high, provided a slot is free and state is IDLE.
- Divider:
  - Counts 0..TICK_DIV-1 while game_run=1.
  - move_tick=1 for exactly the cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - game_run=0 holds the count at 0 and forces move_tick=0.
- scan_idx: increments every clock and wraps from NUM_SLOTS-1 to 0. Runs regardless of game_run.
- Free slot select: lowest index i with slot_flying[i]=0, evaluated combinationally each cycle.
- FSM states:
  - IDLE:
    - rise & game_run & free slot -> FIRE; fire[i] is registered high.
    - rise & game_run & no free slot -> ARM.
  - ARM: waits for any free slot, then -> FIRE. Further rises while in ARM are ignored (no queueing).
  - FIRE:
    - fire is high for this single cycle; shots_fired += 1, saturating at all-ones.
    - Next state COOLDOWN with cooldown counter = COOLDOWN_TICKS.
  - COOLDOWN:
    - Decrements the counter on each move_tick.
    - When a move_tick occurs with counter=1 -> IDLE.
    - Rises seen during COOLDOWN are dropped.
- game_run=0 in any state: next state IDLE, fire=0, cooldown cleared. shots_fired keeps its value.
- A slot freeing in the same cycle as rise counts as free, because slot_flying is sampled that cycle.
- fire never targets a slot whose slot_flying=1 in the cycle the pulse is decided.
- fire is never asserted in two consecutive cycles.
- Reset asserted during FIRE: fire drops to 0 on the next edge and shots_fired is cleared.

Optional Feature:
- Macro AUTOFIRE_EN.
- Defined: in IDLE, sync2=1 (button held) is treated as a request on every cycle, not only on rise. Holding the button fires every COOLDOWN_TICKS move_ticks while slots are available; ARM is entered the same way when no slot is free.
- Undefined: only rising edges create requests; a held button yields exactly one shot.

Test Plan:
- Simulation parameters for all scenarios: NUM_SLOTS=4, TICK_DIV=4, COOLDOWN_TICKS=2.
- Reset: hold reset 3 cycles, game_run=1 -> all outputs 0, scan_idx=0; first move_tick on the 4th cycle after reset release, then every 4 cycles.
- Single shot: slot_flying=0000, pulse shoot_btn high for 5 cycles -> fire=0001 for one cycle, 3 cycles after the first sampling edge; shots_fired=1; the next press is ignored until 2 move_ticks have elapsed.
- Slot allocation: slot_flying=0011 -> fire=0100. Then slot_flying=1111, press -> busy=1, state ARM, no fire. Release slot 1 (slot_flying=1101) -> fire=0010 the next cycle.
- game_run drop: game_run=0 while in COOLDOWN -> move_tick stays 0, state IDLE next cycle, shots_fired unchanged. Press while game_run=0 -> no fire.
- Saturation: force 255 shots with CNT_W=8 -> shots_fired stays 255 after the 256th fire.
- AUTOFIRE_EN defined: hold shoot_btn for 40 cycles with all slots free -> fire pulses spaced by the 2-move_tick cooldown, rotating through the slots 0001, 0010, ... as slot_flying is set. AUTOFIRE_EN undefined: the same stimulus gives exactly one pulse.
